// File: rtl/x_design_pkg.sv
// Shared constants and types for the x_design clock-domain crossing demonstrator.
// Build option: define XDESIGN_SYNC3_EN to use 3-stage req/ack synchronisers (default is 2).
package x_design_pkg;

    // Default data width of the operand buses, the phase buses and both outputs
    localparam int DEFAULT_BW = 64;

    // Depth of the req and ack synchronisers
`ifdef XDESIGN_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    // One data word at the default width
    typedef logic [DEFAULT_BW-1:0] word_t;

endpackage

// File: rtl/x_design_sync.sv
// Single-bit multi-stage synchroniser that advances only on its domain's clock-enable tick.
// Build option: the depth comes from SYNC_STAGES, which is 3 when XDESIGN_SYNC3_EN is defined.
module x_design_sync
    import x_design_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stg;

    // Shift the incoming level one stage per tick of the receiving domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg <= '0;
        end else if (ce) begin
            stg <= {stg[STAGES-2:0], d};
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/x_design.sv
// Two-domain crossing demonstrator. A word f = (aaa & bbb) | (ccc ^ eee) is built in domain 0
// and handed to domain 1 twice: qbad samples the domain-0 register directly (may tear),
// qgood is loaded through a toggle request/acknowledge handshake (always coherent).
// The domains are clock-enable ticks derived from rising edges of clk0[0] / clk1[0].
// Build option: define XDESIGN_SYNC3_EN for 3-stage synchronisers (qgood one ce1 tick later).
//
// Handshake: domain 0 owns req and hold. When its synchronised copy of ack equals req the
// channel is idle: it captures f into hold and toggles req. Domain 1 sees the synchronised req
// differ from seen, copies hold into qgood and sets seen (= ack) to match. hold is never written
// while req != ack_s, so domain 1 always reads a stable hold.
module x_design
    import x_design_pkg::*;
#(
    parameter int BW = DEFAULT_BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] aaa,
    input  logic [BW-1:0] bbb,
    input  logic [BW-1:0] ccc,
    input  logic [BW-1:0] eee,
    input  logic [BW-1:0] clk0,
    input  logic [BW-1:0] clk1,
    output logic [BW-1:0] qbad,
    output logic [BW-1:0] qgood
);

    // Only bit 0 of each phase bus carries the domain clock level
    logic unused_phase_bits;
    assign unused_phase_bits = ^{clk0[BW-1:1], clk1[BW-1:1]};

    logic          p0_d;
    logic          p1_d;
    logic          ce0;
    logic          ce1;
    logic [BW-1:0] f;
    logic [BW-1:0] r0;
    logic [BW-1:0] hold;
    logic          req;
    logic          seen;
    logic          ack;
    logic          req_s;
    logic          ack_s;

    // Remember last phase levels so a rising level change becomes a one-cycle tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_d <= 1'b0;
            p1_d <= 1'b0;
        end else begin
            p0_d <= clk0[0];
            p1_d <= clk1[0];
        end
    end

    assign ce0 = clk0[0] & ~p0_d;
    assign ce1 = clk1[0] & ~p1_d;

    // Bitwise data function, no carries between bits
    assign f = (aaa & bbb) | (ccc ^ eee);

    // Domain 0: free-running data register plus snapshot capture when the channel is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0   <= '0;
            hold <= '0;
            req  <= 1'b0;
        end else if (ce0) begin
            r0 <= f;
            if (ack_s == req) begin
                hold <= f;
                req  <= ~req;
            end
        end
    end

    // Domain 1: raw sample of r0 and handshake-protected load of the snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qbad  <= '0;
            qgood <= '0;
            seen  <= 1'b0;
        end else if (ce1) begin
            qbad <= r0;
            if (req_s != seen) begin
                qgood <= hold;
                seen  <= req_s;
            end
        end
    end

    assign ack = seen;

    // Request crosses into domain 1
    x_design_sync #(
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .ce  (ce1),
        .d   (req),
        .q   (req_s)
    );

    // Acknowledge crosses back into domain 0
    x_design_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .ce  (ce0),
        .d   (ack),
        .q   (ack_s)
    );

endmodule

// File: tb/tb_x_design.sv
// Directed self-checking bench for x_design: reset, basic transfer, busy drop,
// phase-bus decoding, simultaneous ticks and reset in the middle of a transfer.
module tb_x_design;

`ifdef XDESIGN_SYNC3_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    logic        clk;
    logic        rst;
    logic [63:0] aaa;
    logic [63:0] bbb;
    logic [63:0] ccc;
    logic [63:0] eee;
    logic [63:0] clk0;
    logic [63:0] clk1;
    logic [63:0] qbad;
    logic [63:0] qgood;

    int checks;
    int errors;

    x_design dut (
        .clk   (clk),
        .rst   (rst),
        .aaa   (aaa),
        .bbb   (bbb),
        .ccc   (ccc),
        .eee   (eee),
        .clk0  (clk0),
        .clk1  (clk1),
        .qbad  (qbad),
        .qgood (qgood)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle with given phase bit0 levels; upper phase bits randomised
    task automatic cyc(input logic b0, input logic b1);
        logic [63:0] r0v;
        logic [63:0] r1v;
        @(negedge clk);
        r0v  = {$urandom, $urandom};
        r1v  = {$urandom, $urandom};
        clk0 = {r0v[63:1], b0};
        clk1 = {r1v[63:1], b1};
        @(posedge clk);
        #1;
    endtask

    task automatic tick0();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic tick1();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            aaa  = {$urandom, $urandom};
            bbb  = {$urandom, $urandom};
            ccc  = {$urandom, $urandom};
            eee  = {$urandom, $urandom};
            clk0 = {$urandom, $urandom};
            clk1 = {$urandom, $urandom};
            @(posedge clk);
            #1;
            checks++;
            if (qbad !== 64'h0) begin
                errors++;
                $display("FAIL reset_qbad cycle %0d: got %h expected 0", i, qbad);
            end
            checks++;
            if (qgood !== 64'h0) begin
                errors++;
                $display("FAIL reset_qgood cycle %0d: got %h expected 0", i, qgood);
            end
        end
        @(negedge clk);
        clk0 = 64'h0;
        clk1 = 64'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0);
            checks++;
            if (qbad !== 64'h0 || qgood !== 64'h0) begin
                errors++;
                $display("FAIL post_reset_idle: got qbad=%h qgood=%h expected 0/0", qbad, qgood);
            end
        end
    endtask

    task automatic test_basic();
        aaa = 64'hFF;
        bbb = 64'h0F;
        ccc = 64'h30;
        eee = 64'h10;
        tick0();
        for (int i = 1; i <= STAGES + 1; i++) begin
            tick1();
            checks++;
            if (qbad !== 64'h2F) begin
                errors++;
                $display("FAIL basic_qbad tick %0d: got %h expected 2f", i, qbad);
            end
            checks++;
            if (qgood !== ((i == STAGES + 1) ? 64'h2F : 64'h0)) begin
                errors++;
                $display("FAIL basic_qgood tick %0d: got %h expected %h", i, qgood,
                         (i == STAGES + 1) ? 64'h2F : 64'h0);
            end
        end
    endtask

    task automatic test_busy_drop();
        aaa = 64'hF0;
        // ack_s has not caught up yet: these ticks update r0 only
        for (int i = 0; i < STAGES; i++) begin
            tick0();
        end
        tick1();
        checks++;
        if (qbad !== 64'h20) begin
            errors++;
            $display("FAIL busy_qbad: got %h expected 20", qbad);
        end
        for (int i = 0; i < STAGES + 1; i++) begin
            tick1();
            checks++;
            if (qgood !== 64'h2F) begin
                errors++;
                $display("FAIL busy_qgood_hold %0d: got %h expected 2f", i, qgood);
            end
        end
        // Channel idle now: this tick is accepted
        tick0();
        for (int i = 1; i <= STAGES + 1; i++) begin
            tick1();
            checks++;
            if (qgood !== ((i == STAGES + 1) ? 64'h20 : 64'h2F)) begin
                errors++;
                $display("FAIL busy_next_snapshot tick %0d: got %h expected %h", i, qgood,
                         (i == STAGES + 1) ? 64'h20 : 64'h2F);
            end
        end
    endtask

    task automatic test_phase();
        logic [1:0]  pats[5];
        logic [63:0] exps[5];
        logic [63:0] rv;
        pats = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
        exps = '{64'h20, 64'h20, 64'h102, 64'h102, 64'h104};
        aaa = 64'h0;
        bbb = 64'h0;
        eee = 64'h0;
        for (int k = 0; k < 5; k++) begin
            ccc = 64'h100 + 64'(k);
            @(negedge clk);
            rv   = {$urandom, $urandom};
            clk0 = {rv[63:2], pats[k]};
            clk1 = 64'h0;
            @(posedge clk);
            #1;
            // ce1 tick while clk0 bit0 holds its level
            @(negedge clk);
            rv   = {$urandom, $urandom};
            clk0 = {rv[63:1], pats[k][0]};
            clk1 = 64'h1;
            @(posedge clk);
            #1;
            @(negedge clk);
            rv   = {$urandom, $urandom};
            clk0 = {rv[63:1], pats[k][0]};
            clk1 = 64'h0;
            @(posedge clk);
            #1;
            checks++;
            if (qbad !== exps[k]) begin
                errors++;
                $display("FAIL phase_step %0d: got %h expected %h", k, qbad, exps[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        cyc(1'b0, 1'b0);
        aaa = 64'h0;
        bbb = 64'h0;
        eee = 64'h0;
        ccc = 64'h55;
        cyc(1'b1, 1'b1);
        checks++;
        if (qbad !== 64'h104) begin
            errors++;
            $display("FAIL simul_old: got %h expected 104", qbad);
        end
        cyc(1'b0, 1'b0);
        tick1();
        checks++;
        if (qbad !== 64'h55) begin
            errors++;
            $display("FAIL simul_new: got %h expected 55", qbad);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        aaa = 64'h0;
        bbb = 64'h0;
        eee = 64'h0;
        ccc = 64'hA5A5;
        tick0();
        tick1();
        // Abort the transfer after req has started crossing
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (qbad !== 64'h0 || qgood !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: got qbad=%h qgood=%h expected 0/0", qbad, qgood);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < STAGES + 3; i++) begin
            tick1();
            checks++;
            if (qgood !== 64'h0) begin
                errors++;
                $display("FAIL mid_reset_no_load %0d: got %h expected 0", i, qgood);
            end
        end
        tick0();
        for (int i = 0; i < STAGES + 1; i++) begin
            tick1();
        end
        checks++;
        if (qgood !== 64'hA5A5) begin
            errors++;
            $display("FAIL mid_reset_new_snapshot: got %h expected a5a5", qgood);
        end
        checks++;
        if (qbad !== 64'hA5A5) begin
            errors++;
            $display("FAIL mid_reset_qbad: got %h expected a5a5", qbad);
        end
    endtask

    // Test sequence
    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        aaa  = 64'h0;
        bbb  = 64'h0;
        ccc  = 64'h0;
        eee  = 64'h0;
        clk0 = 64'h0;
        clk1 = 64'h0;
        test_reset();
        test_basic();
        test_busy_drop();
        test_phase();
        test_simultaneous();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
